// File: rtl/csr_pkg.sv
// Exception cause encoding shared with the CSR unit.
package csr_pkg;
    typedef logic [3:0] except_code_t;
endpackage

// File: rtl/expipe_pkg.sv
// Execution-pipe shared types: feeder FSM states and stall-combining modes.
package expipe_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } feeder_state_e;

    localparam int STALL_ALL = 0;
    localparam int STALL_ANY = 1;
endpackage

// File: rtl/len5_pkg.sv
// Core-wide instruction word geometry.
package len5_pkg;
    localparam int ILEN = 32;
endpackage

// File: rtl/ins_feeder_buf.sv
// Program buffer: DEPTH x WIDTH register file, one write port, one async read port.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none here; the feeder only writes when it has room.
module ins_feeder_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    // Contents deliberately survive reset; the owner tracks validity by count.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ins_feeder.sv
// Instruction feeder: loads a program into a buffer, then replays it one word per cycle.
// Latency: ins_o is combinational from the buffer; one instruction issued per unstalled RUN cycle.
// Backpressure: loads gated by load_ready_o (IDLE and not full); issue held by the combined stall_i.
module ins_feeder
    import len5_pkg::*, csr_pkg::*, expipe_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int NUM_STALL    = 2,
    parameter int STALL_MODE   = STALL_ALL,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       load_valid_i,
    input  logic [ILEN-1:0]            load_ins_i,
    output logic                       load_ready_o,
    input  logic                       start_i,
    input  logic                       clr_i,
    input  logic [NUM_STALL-1:0]       stall_i,
    input  logic                       except_raised_i,
    input  except_code_t               except_code_i,
    output logic [ILEN-1:0]            ins_o,
    output logic                       ins_valid_o,
    output logic                       flush_o,
    output logic                       done_o,
    output except_code_t               except_code_o,
    output logic                       except_seen_o,
    output logic [$clog2(DEPTH+1)-1:0] issued_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    feeder_state_e state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    except_code_t  except_code_q, except_code_d;
    logic          except_seen_q, except_seen_d;

    logic hold;
    logic last_entry;
    logic load_fire;

    assign hold       = (STALL_MODE == STALL_ANY) ? (|stall_i) : (&stall_i);
    assign last_entry = (CW'(rd_ptr_q) == (count_q - CW'(1)));
    assign load_fire  = load_valid_i && load_ready_o;

    ins_feeder_buf #(
        .DEPTH (DEPTH),
        .WIDTH (ILEN)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (load_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_ins_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ins_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            flush_cnt_q   <= '0;
            except_code_q <= '0;
            except_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            flush_cnt_q   <= flush_cnt_d;
            except_code_q <= except_code_d;
            except_seen_q <= except_seen_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        issued_d      = issued_q;
        flush_cnt_d   = flush_cnt_q;
        except_code_d = except_code_q;
        except_seen_d = except_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    count_d  = count_q + CW'(1);
                end
                if (start_i && (count_q != '0)) begin
                    state_d       = ST_RUN;
                    rd_ptr_d      = '0;
                    issued_d      = '0;
                    except_seen_d = 1'b0;
                end
            end
            ST_RUN: begin
                // An exception freezes rd_ptr so the faulting entry stays identifiable.
                if (except_raised_i) begin
                    except_code_d = except_code_i;
                    except_seen_d = 1'b1;
                    flush_cnt_d   = '0;
                    state_d       = ST_FLUSH;
                end else if (!hold) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    issued_d = issued_q + CW'(1);
                    if (last_entry) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_HALT;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_HALT: begin
                if (clr_i) begin
                    state_d  = ST_IDLE;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (start_i) begin
                    state_d       = ST_RUN;
                    rd_ptr_d      = '0;
                    issued_d      = '0;
                    except_seen_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decode straight from state so reset clears them without a clock.
    always_comb begin
        load_ready_o = 1'b0;
        ins_valid_o  = 1'b0;
        flush_o      = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            ST_IDLE:  load_ready_o = (count_q < CW'(DEPTH));
            ST_RUN:   ins_valid_o  = 1'b1;
            ST_FLUSH: flush_o      = 1'b1;
            ST_HALT:  done_o       = 1'b1;
            default:  ;
        endcase
    end

    assign except_code_o = except_code_q;
    assign except_seen_o = except_seen_q;
    assign issued_cnt_o  = issued_q;

endmodule

// File: tb/tb_ins_feeder.sv
// Self-checking bench for ins_feeder: two instances (all-stall and any-stall modes) vs a program-level model.
module tb_ins_feeder;
    import csr_pkg::*;

    localparam int DEPTH = 16;
    localparam int FC    = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

    logic         clk;
    logic         rst_n;
    logic         load_valid;
    logic [31:0]  load_ins;
    logic         start;
    logic         clr;
    logic [1:0]   stall;
    logic         exc;
    except_code_t exc_code;

    logic [1:0]   ready, ivld, flush, done, seen;
    logic [31:0]  ins  [2];
    except_code_t code [2];
    logic [4:0]   iss  [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] m_prog [2][DEPTH];
    int          m_len  [2];
    int          m_st   [2];
    int          m_rd   [2];
    int          m_iss  [2];
    int          m_fl   [2];
    logic [3:0]  m_code [2];
    bit          m_seen [2];

    ins_feeder #(.DEPTH(DEPTH), .NUM_STALL(2), .STALL_MODE(0), .FLUSH_CYCLES(FC)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .load_valid_i(load_valid), .load_ins_i(load_ins),
        .load_ready_o(ready[0]), .start_i(start), .clr_i(clr), .stall_i(stall),
        .except_raised_i(exc), .except_code_i(exc_code), .ins_o(ins[0]),
        .ins_valid_o(ivld[0]), .flush_o(flush[0]), .done_o(done[0]),
        .except_code_o(code[0]), .except_seen_o(seen[0]), .issued_cnt_o(iss[0])
    );

    ins_feeder #(.DEPTH(DEPTH), .NUM_STALL(2), .STALL_MODE(1), .FLUSH_CYCLES(FC)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .load_valid_i(load_valid), .load_ins_i(load_ins),
        .load_ready_o(ready[1]), .start_i(start), .clr_i(clr), .stall_i(stall),
        .except_raised_i(exc), .except_code_i(exc_code), .ins_o(ins[1]),
        .ins_valid_o(ivld[1]), .flush_o(flush[1]), .done_o(done[1]),
        .except_code_o(code[1]), .except_seen_o(seen[1]), .issued_cnt_o(iss[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_len[i]  = 0;
        m_st[i]   = M_IDLE;
        m_rd[i]   = 0;
        m_iss[i]  = 0;
        m_fl[i]   = 0;
        m_code[i] = 4'd0;
        m_seen[i] = 1'b0;
    endtask

    task automatic model_begin_run(input int i);
        m_st[i]   = M_RUN;
        m_rd[i]   = 0;
        m_iss[i]  = 0;
        m_seen[i] = 1'b0;
    endtask

    // One clock of the program-level behaviour, using the inputs currently driven.
    task automatic model_step(input int i);
        bit hold;
        bit go;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        hold = (i == 0) ? (stall == 2'b11) : (stall != 2'b00);
        if (m_st[i] == M_IDLE) begin
            go = start && (m_len[i] > 0);
            if (load_valid && m_len[i] < DEPTH) begin
                m_prog[i][m_len[i]] = load_ins;
                m_len[i]++;
            end
            if (go) model_begin_run(i);
        end else if (m_st[i] == M_RUN) begin
            if (exc) begin
                m_code[i] = exc_code;
                m_seen[i] = 1'b1;
                m_fl[i]   = FC;
                m_st[i]   = M_FLUSH;
            end else if (!hold) begin
                if (m_rd[i] == m_len[i] - 1) m_st[i] = M_HALT;
                m_rd[i]++;
                m_iss[i]++;
            end
        end else if (m_st[i] == M_FLUSH) begin
            m_fl[i]--;
            if (m_fl[i] == 0) m_st[i] = M_HALT;
        end else begin
            if (clr) m_len[i] = 0;
            if (clr) m_st[i] = M_IDLE;
            else if (start) model_begin_run(i);
        end
    endtask

    task automatic compare(input int i);
        string p;
        p = (i == 0) ? "all_mode" : "any_mode";
        chk({p, "_load_ready"}, 32'(ready[i]), 32'(m_st[i] == M_IDLE && m_len[i] < DEPTH));
        chk({p, "_ins_valid"},  32'(ivld[i]),  32'(m_st[i] == M_RUN));
        if (m_st[i] == M_RUN) chk({p, "_ins"}, ins[i], m_prog[i][m_rd[i]]);
        chk({p, "_flush"},       32'(flush[i]), 32'(m_st[i] == M_FLUSH));
        chk({p, "_done"},        32'(done[i]),  32'(m_st[i] == M_HALT));
        chk({p, "_except_code"}, 32'(code[i]),  32'(m_code[i]));
        chk({p, "_except_seen"}, 32'(seen[i]),  32'(m_seen[i]));
        chk({p, "_issued"},      32'(iss[i]),   32'(m_iss[i]));
    endtask

    // Inputs are already driven; check at the falling edge, then advance one clock.
    task automatic cycle();
        @(negedge clk);
        compare(0);
        compare(1);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        load_valid = 1'b0;
        start      = 1'b0;
        clr        = 1'b0;
        stall      = 2'b00;
        exc        = 1'b0;
        exc_code   = 4'd0;
    endtask

    task automatic load_words(input int n);
        for (int k = 0; k < n; k++) begin
            load_valid = 1'b1;
            load_ins   = $urandom;
            cycle();
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_halt(input bit rand_stall);
        int n;
        n = 0;
        while (!(m_st[0] == M_HALT && m_st[1] == M_HALT) && n < 200) begin
            if (rand_stall) begin
                stall    = 2'($urandom_range(0, 3));
                exc      = ($urandom_range(0, 15) == 0);
                exc_code = 4'($urandom_range(0, 15));
            end
            cycle();
            n++;
        end
        set_idle();
        chk("halt_reached_all_mode", 32'(done[0]), 32'd1);
        chk("halt_reached_any_mode", 32'(done[1]), 32'd1);
    endtask

    task automatic clear_buffer();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        load_ins = '0;
        set_idle();
        model_reset(0);
        model_reset(1);
        #1;
        compare(0);
        compare(1);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Four-word program, no stalls.
        load_words(4);
        cycle();
        pulse_start();
        run_until_halt(1'b0);
        chk("basic_issued", 32'(iss[0]), 32'd4);
        cycle();

        // clr beats start in HALT.
        clr   = 1'b1;
        start = 1'b1;
        cycle();
        set_idle();
        cycle();

        // Overfill: the 17th word must be dropped.
        load_words(DEPTH + 1);
        chk("full_ready_low", 32'(ready[0]), 32'd0);
        cycle();

        // Random stalls and exceptions over the full buffer.
        pulse_start();
        run_until_halt(1'b1);
        clear_buffer();

        // Stall combining: 01 advances only in all-mode; 11 holds both.
        load_words(6);
        pulse_start();
        stall = 2'b01;
        repeat (3) cycle();
        stall = 2'b11;
        repeat (3) cycle();
        stall = 2'b00;
        run_until_halt(1'b0);
        clear_buffer();

        // Exception at the second instruction.
        load_words(4);
        pulse_start();
        cycle();
        exc      = 1'b1;
        exc_code = 4'd5;
        cycle();
        set_idle();
        run_until_halt(1'b0);
        chk("exc2_code",   32'(code[0]), 32'd5);
        chk("exc2_issued", 32'(iss[0]),  32'd1);

        // Exception on the last instruction, then replay.
        pulse_start();
        repeat (3) cycle();
        exc      = 1'b1;
        exc_code = 4'd9;
        cycle();
        set_idle();
        chk("exc_last_flush", 32'(flush[0]), 32'd1);
        run_until_halt(1'b0);
        pulse_start();
        chk("replay_seen_cleared", 32'(seen[0]), 32'd0);
        run_until_halt(1'b0);

        // Asynchronous reset during FLUSH.
        pulse_start();
        exc      = 1'b1;
        exc_code = 4'd3;
        cycle();
        set_idle();
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        chk("async_flush_drop", 32'(flush[0]), 32'd0);
        compare(0);
        compare(1);
        cycle();
        rst_n = 1'b1;
        pulse_start();
        cycle();
        chk("start_ignored_empty", 32'(ivld[0]), 32'd0);

        // Fresh short program after reset.
        load_words(2);
        pulse_start();
        run_until_halt(1'b0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
